image_mem_responder: RTL

- Memory-side responder for the accelerator's image_r BRAM-style port (Addr_A/EN_A/WEN_A/Din_A/Dout_A).
- Stands in for the off-chip image memory: it is preloaded through a valid/ready load stream, then serves the accelerator's reads with fixed latency.
- Sits in the user project next to forward_pass for on-chip self-test and simulation without external pads.

---
 rtl/image_mem_responder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/image_mem_responder.sv
// Image memory responder: stream-loaded word array serving the accelerator's
// BRAM-style image_r port with a fixed read latency.
module image_mem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int DEPTH     = 4096,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [31:0]       image_r_Addr_A,
    input  logic              image_r_EN_A,
    input  logic [1:0]        image_r_WEN_A,
    input  logic [DATA_W-1:0] image_r_Din_A,
    output logic [DATA_W-1:0] image_r_Dout_A,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              mem_ready,
    output logic [15:0]       rd_count,
    output logic              oob_err
);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY} state_t;

    state_t                state, state_nxt;
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  a_idx;
    logic                  beat_acc, load_end;
    logic                  addr_oob, acc_oob, rd_en, wr_en;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [RD_LAT-1:0]     vld_q;
    logic [DATA_W-1:0]     pipe_data [RD_LAT];
    logic [DATA_W-1:0]     hold_q;

    assign a_idx    = image_r_Addr_A[ADDR_BITS-1:0];
    assign addr_oob = image_r_Addr_A >= 32'(DEPTH);
    assign acc_oob  = image_r_EN_A && addr_oob;
    assign rd_en    = image_r_EN_A && (image_r_WEN_A == 2'b00);
    // Port-A writes and load writes live in exclusive states, so they never collide.
    assign wr_en    = image_r_EN_A && (image_r_WEN_A != 2'b00) && !addr_oob
                      && (state == S_READY);
    assign beat_acc = load_valid && load_ready;
    assign load_end = beat_acc && (load_last || (wr_ptr == ADDR_BITS'(DEPTH - 1)));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    // NOTE: each always_comb assigns its outputs a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (load_start)
            state_nxt = S_LOAD;
        else if ((state == S_LOAD) && load_end)
            state_nxt = S_READY;
    end

    // A beat presented alongside load_start is refused so the restart begins at word 0.
    always_comb begin
        load_ready = (state == S_LOAD) && !load_start;
        mem_ready  = (state == S_READY);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr    <= '0;
            load_done <= 1'b0;
            rd_count  <= '0;
            oob_err   <= 1'b0;
        end else begin
            load_done <= load_end;
            if (load_start) begin
                wr_ptr   <= '0;
                rd_count <= '0;
                oob_err  <= 1'b0;
            end else begin
                if (beat_acc)
                    wr_ptr <= wr_ptr + ADDR_BITS'(1);
                if (rd_en && (rd_count != 16'hFFFF))
                    rd_count <= rd_count + 16'd1;
                if (acc_oob)
                    oob_err <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; contents are undefined until a load writes them.
    always_ff @(posedge ap_clk) begin
        if (beat_acc) begin
            mem[wr_ptr] <= load_data;
        end else if (wr_en) begin
            if (image_r_WEN_A[0]) mem[a_idx][7:0]  <= image_r_Din_A[7:0];
            if (image_r_WEN_A[1]) mem[a_idx][15:8] <= image_r_Din_A[15:8];
        end
    end

    always_comb begin
        rd_word = '0;
        if (!addr_oob)
            rd_word = mem[a_idx];
    end

    // Free-running read pipeline; the output only takes a stage value when it carries a read.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_q  <= '0;
            hold_q <= '0;
            for (int i = 0; i < RD_LAT; i++)
                pipe_data[i] <= '0;
        end else begin
            vld_q        <= RD_LAT'({vld_q, rd_en});
            hold_q       <= image_r_Dout_A;
            pipe_data[0] <= rd_word;
            for (int i = 1; i < RD_LAT; i++)
                pipe_data[i] <= pipe_data[i-1];
        end
    end

    assign image_r_Dout_A = vld_q[RD_LAT-1] ? pipe_data[RD_LAT-1] : hold_q;

endmodule
